// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle ARM-subset controller: state codes,
// ALU control codes, instruction field constants and datapath mux selects.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_LINK     = 4'd10
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    // Data-processing cmd to ALU control; CMP subtracts, unknown cmds add.
    function automatic logic [3:0] alu_decode(input logic [3:0] cmd);
        logic [3:0] ctl;
        case (cmd)
            CMD_ADD: ctl = ALU_ADD;
            CMD_SUB: ctl = ALU_SUB;
            CMD_AND: ctl = ALU_AND;
            CMD_ORR: ctl = ALU_ORR;
            CMD_MOV: ctl = ALU_MOV;
            CMD_CMP: ctl = ALU_SUB;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// ARM condition-code evaluation: COND x {N,Z,C,V} -> CondEx.
module cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n_s, z_s, c_s, v_s, ge_s;

    assign {n_s, z_s, c_s, v_s} = flags;
    assign ge_s = (n_s == v_s);

    // Full ARM condition table; 1111 is treated as never.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_s;
            4'b0001: cond_ex = ~z_s;
            4'b0010: cond_ex = c_s;
            4'b0011: cond_ex = ~c_s;
            4'b0100: cond_ex = n_s;
            4'b0101: cond_ex = ~n_s;
            4'b0110: cond_ex = v_s;
            4'b0111: cond_ex = ~v_s;
            4'b1000: cond_ex = c_s & ~z_s;
            4'b1001: cond_ex = ~c_s | z_s;
            4'b1010: cond_ex = ge_s;
            4'b1011: cond_ex = ~ge_s;
            4'b1100: cond_ex = ~z_s & ge_s;
            4'b1101: cond_ex = z_s | ~ge_s;
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the ARM-subset datapath with NZCV flag register.
// Optional BL support (DECODE -> LINK -> BRANCH) is enabled by CTRL_BL_EN.
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] OP,
    input  logic [5:0] FUNCT,
    input  logic [3:0] RD,
    input  logic [3:0] COND,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [1:0] RegSrc,
    output logic       LinkWrite,
    output logic [3:0] Flags,
    output logic [3:0] STATE
);

    state_t     state_r, next_state_s, eff_state_s;
    logic [3:0] flags_r;
    logic [3:0] cmd_s;
    logic       cond_ex_s;
    logic       flag_load_s;
    logic       pc_write_s, mem_write_s, ir_write_s, reg_write_s, link_write_s;

    assign cmd_s = FUNCT[4:1];

    cond_check u_cond_check (
        .cond    (COND),
        .flags   (flags_r),
        .cond_ex (cond_ex_s)
    );

    assign flag_load_s = ((state_r == S_EXECUTER) || (state_r == S_EXECUTEI)) &&
                         (FUNCT[0] || (cmd_s == CMD_CMP));

    // State and flag registers; reset wins over any in-flight instruction.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= S_FETCH;
            flags_r <= 4'b0000;
        end else begin
            state_r <= next_state_s;
            if (flag_load_s) begin
                flags_r <= ALUFlags;
            end else begin
                flags_r <= flags_r;
            end
        end
    end

    // Next-state logic; CondEx is only consulted in DECODE.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:    next_state_s = S_DECODE;
            S_DECODE: begin
                if (!cond_ex_s) begin
                    next_state_s = S_FETCH;
                end else begin
                    case (OP)
                        OP_MEM:  next_state_s = S_MEMADR;
                        OP_DP:   next_state_s = FUNCT[5] ? S_EXECUTEI : S_EXECUTER;
`ifdef CTRL_BL_EN
                        OP_BR:   next_state_s = FUNCT[4] ? S_LINK : S_BRANCH;
`else
                        OP_BR:   next_state_s = S_BRANCH;
`endif
                        default: next_state_s = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   next_state_s = FUNCT[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state_s = S_MEMWB;
            S_EXECUTER: next_state_s = S_ALUWB;
            S_EXECUTEI: next_state_s = S_ALUWB;
`ifdef CTRL_BL_EN
            S_LINK:     next_state_s = S_BRANCH;
`endif
            default:    next_state_s = S_FETCH;
        endcase
    end

    // While reset is held the outputs decode as FETCH with all strobes gated.
    assign eff_state_s = RESET ? S_FETCH : state_r;

    // Moore output decode from the effective state.
    always_comb begin
        pc_write_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        link_write_s = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_RD2;
        ALUControl   = ALU_ADD;
        ImmSrc       = IMM_DP;
        RegSrc       = 2'b00;
        case (eff_state_s)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALU;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_MEM;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = RES_RDATA;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
                RegSrc      = 2'b10;
            end
            S_EXECUTER: ALUControl = alu_decode(cmd_s);
            S_EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = alu_decode(cmd_s);
            end
            S_ALUWB: begin
                reg_write_s = (cmd_s != CMD_CMP);
                pc_write_s  = (cmd_s != CMD_CMP) && (RD == 4'b1111);
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_BR;
                ResultSrc  = RES_ALU;
                pc_write_s = 1'b1;
                RegSrc     = 2'b01;
            end
`ifdef CTRL_BL_EN
            S_LINK: begin
                link_write_s = 1'b1;
                reg_write_s  = 1'b1;
            end
`endif
            default: ALUControl = ALU_ADD;
        endcase
    end

    assign PCWrite   = pc_write_s   & ~RESET;
    assign MemWrite  = mem_write_s  & ~RESET;
    assign IRWrite   = ir_write_s   & ~RESET;
    assign RegWrite  = reg_write_s  & ~RESET;
    assign LinkWrite = link_write_s & ~RESET;
    assign Flags     = flags_r;
    assign STATE     = eff_state_s;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the ARM-subset processor. It steps one shared ALU, memory port and register file through FETCH/DECODE/EXECUTE/writeback phases, one instruction at a time. It also keeps the architectural NZCV flag register and evaluates condition codes. It sits between the instruction register fields and the multi-cycle datapath, which it drives.

## Interface
Parameters:
- none; all encodings are package constants.

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- OP  in  2  instruction [27:26]
- FUNCT  in  6  instruction [25:20]; [5]=I, [4:1]=cmd, [0]=S/L
- RD  in  4  instruction [15:12]
- COND  in  4  instruction [31:28]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- PCWrite  out  1  load PC from Result
- AdrSrc  out  1  0=PC, 1=ALUOut to memory address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load instruction register
- ResultSrc  out  2  00=ALUOut, 01=read data, 10=ALU result direct
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4
- ALUControl  out  4  ADD 0100, SUB 0010, AND 0000, ORR 1100, MOV 1101
- ImmSrc  out  2  00=DP imm8, 01=mem imm12, 10=branch imm24
- RegWrite  out  1  register file write
- RegSrc  out  2  [0]=RA1 is R15, [1]=RA2 is RD
- LinkWrite  out  1  write PC into R14
- Flags  out  4  registered NZCV
- STATE  out  4  current state code, for debug

## Operation
- Moore FSM; outputs decode from the current state, plus instruction fields where noted.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. Next state:
  - CondEx=0 → FETCH.
  - OP=01 → MEMADR.
  - OP=00 with I=0 → EXECUTER; with I=1 → EXECUTEI.
  - OP=10 → BRANCH.
  - OP=11 → FETCH (no operation).
- MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ADD. Next: L=1 → MEMREAD, else MEMWRITE.
- MEMREAD: AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, RegSrc[1]=1. Next: FETCH.
- EXECUTER / EXECUTEI:
  - ALUSrcA=0; ALUSrcB=00 or 01; ImmSrc=00.
  - ALUControl comes from cmd: ADD 0100→0100, SUB 0010→0010, AND 0000→0000, ORR 1100→1100, MOV 1101→1101, CMP 1010→0010. Any other cmd → 0100.
  - Next: ALUWB.
- ALUWB: ResultSrc=00. RegWrite=1 unless cmd=CMP. If RegWrite=1 and RD=1111, PCWrite=1 as well. Next: FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite=1, RegSrc[0]=1. Next: FETCH.
- CondEx rules:
  - Full ARM table, evaluated on the registered Flags.
  - COND=1110 → 1; COND=1111 → 0.
  - CondEx is sampled only in DECODE.
- Flag register:
  - Loads ALUFlags on the edge that leaves EXECUTER/EXECUTEI when S=1 or cmd=CMP.
  - Holds otherwise; never written in any other state.

## Timing
- Cycles per instruction: B 3, DP 4, STR 4, LDR 5, not-executed 2, OP=11 2. BL is 4 with CTRL_BL_EN.
- PC is updated at the end of FETCH; the DECODE PC read sees PC+4. R15 reads return PC+8 from the datapath.
- RESET=1 at an edge: STATE←FETCH (code 0) and Flags←0000. This holds regardless of state, including mid-instruction.
- While RESET=1, outputs are forced to: PCWrite, MemWrite, IRWrite, RegWrite, LinkWrite = 0. All other outputs decode as FETCH.
- The first fetch occurs in the first cycle with RESET=0.
- A store interrupted by reset never asserts MemWrite after the reset edge.

## Configuration
- CTRL_BL_EN defined:
  - OP=10 with FUNCT[4]=1 and CondEx=1 goes DECODE → LINK → BRANCH.
  - LINK: LinkWrite=1, RegWrite=1; R14 receives the PC value (instruction address+4).
- CTRL_BL_EN undefined:
  - BL is executed as B.
  - LINK state code is unused; LinkWrite is tied 0.

## Structure
- Package `multicycle_pkg` holds:
  - the state encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, LINK 10;
  - ALUControl codes, the cmd field constants, and the ResultSrc/ALUSrcB/ImmSrc codes.
- Sub-module `cond_check`: combinational COND × NZCV → CondEx.

## Test plan
- Reset, then ADD R1,R2,R3 (OP=00, FUNCT=001000, COND=1110) → states 0,1,6,8,0; RegWrite=1 only in ALUWB; PCWrite in FETCH only.
- CMP with ALUFlags=0100, then BEQ (COND=0000) → Flags=0100 after EXECUTER; BEQ passes through BRANCH with PCWrite=1; total 3 cycles.
- BNE (COND=0001) with Z=1 → DECODE→FETCH, no PCWrite in DECODE; total 2 cycles.
- LDR (OP=01, FUNCT=011001) → 0,1,2,3,4,0; ResultSrc=01 and RegWrite=1 in MEMWB. STR (FUNCT=011000) → MemWrite=1 exactly one cycle.
- MOV PC,R2 (RD=1111) → ALUWB asserts RegWrite=1 and PCWrite=1 together.
- RESET asserted in MEMWRITE → next state FETCH, MemWrite=0, Flags=0000. With CTRL_BL_EN, BL → states 0,1,10,9,0, LinkWrite=1 in LINK.
